// File: rtl/id_decode_stage.sv
// RV32I decode stage: field split, immediate generation and format classification,
// held in a valid/ready pipeline register with flush and a saturating illegal counter.
module id_decode_stage #(
  parameter int unsigned BITS     = 32,
  parameter int unsigned XLEN     = 32,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FLUSH,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BITS-1:0]     INSTR,
  input  logic [XLEN-1:0]     PC_IN,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [6:0]          opcode,
  output logic [4:0]          rd,
  output logic [2:0]          funct3,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2,
  output logic [6:0]          funct7,
  output logic [XLEN-1:0]     imm,
  output logic [2:0]          fmt,
  output logic                illegal,
  output logic [XLEN-1:0]     pc_out,
  output logic [CNT_BITS-1:0] illegal_cnt
);

  typedef enum logic [2:0] {
    FmtR    = 3'd0,
    FmtI    = 3'd1,
    FmtS    = 3'd2,
    FmtB    = 3'd3,
    FmtU    = 3'd4,
    FmtJ    = 3'd5,
    FmtNone = 3'd7
  } fmt_e;

  logic [31:0] ins;
  fmt_e        dec_fmt;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [31:0] dec_imm32;
  logic        dec_illegal;
  logic        accept;

  logic                valid_q;
  logic [6:0]          opcode_q;
  logic [4:0]          rd_q, rs1_q, rs2_q;
  logic [2:0]          funct3_q;
  logic [6:0]          funct7_q;
  logic [XLEN-1:0]     imm_q, pc_q;
  fmt_e                fmt_q;
  logic                illegal_q;
  logic [CNT_BITS-1:0] cnt_q;

  assign ins      = INSTR[31:0];
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_fmt = FmtNone;
    unique case (ins[6:0])
      7'b0110011:                                              dec_fmt = FmtR;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0001111: dec_fmt = FmtI;
      7'b0100011:                                              dec_fmt = FmtS;
      7'b1100011:                                              dec_fmt = FmtB;
      7'b0110111, 7'b0010111:                                  dec_fmt = FmtU;
      7'b1101111:                                              dec_fmt = FmtJ;
      default:                                                 dec_fmt = FmtNone;
    endcase
  end

  // Register fields are zeroed where the format does not use them.
  always_comb begin
    dec_rd    = ins[11:7];
    dec_rs1   = ins[19:15];
    dec_rs2   = '0;
    dec_imm32 = '0;
    unique case (dec_fmt)
      FmtR: dec_rs2 = ins[24:20];
      FmtI: dec_imm32 = {{20{ins[31]}}, ins[31:20]};
      FmtS: begin
        dec_rd    = '0;
        dec_rs2   = ins[24:20];
        dec_imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      FmtB: begin
        dec_rd    = '0;
        dec_rs2   = ins[24:20];
        dec_imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      FmtU: begin
        dec_rs1   = '0;
        dec_imm32 = {ins[31:12], 12'b0};
      end
      FmtJ: begin
        dec_rs1   = '0;
        dec_imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign dec_illegal = (ins[1:0] != 2'b11) || (dec_fmt == FmtNone) ||
                       ((dec_fmt == FmtR) && (ins[31:25] != 7'b0000000) &&
                        (ins[31:25] != 7'b0100000));

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      rd_q      <= '0;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      funct7_q  <= '0;
      imm_q     <= '0;
      fmt_q     <= FmtNone;
      illegal_q <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
    end else if (FLUSH) begin
      // Data registers keep stale values; only valid matters downstream.
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q   <= 1'b1;
      opcode_q  <= ins[6:0];
      rd_q      <= dec_rd;
      funct3_q  <= ins[14:12];
      rs1_q     <= dec_rs1;
      rs2_q     <= dec_rs2;
      funct7_q  <= ins[31:25];
      imm_q     <= XLEN'($signed(dec_imm32));
      fmt_q     <= dec_fmt;
      illegal_q <= dec_illegal;
      pc_q      <= PC_IN;
      if (dec_illegal && (cnt_q != '1)) begin
        cnt_q <= cnt_q + CNT_BITS'(1);
      end
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid   = valid_q;
  assign opcode      = opcode_q;
  assign rd          = rd_q;
  assign funct3      = funct3_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign funct7      = funct7_q;
  assign imm         = imm_q;
  assign fmt         = fmt_q;
  assign illegal     = illegal_q;
  assign pc_out      = pc_q;
  assign illegal_cnt = cnt_q;

endmodule
